// File: rtl/gray_step_ctrl.sv
// Command-driven Gray-code position sequencer: steps a binary position up or down
// on a programmable interval and presents it Gray-coded, with busy/step/done status.
module gray_step_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic             step_pulse,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic             step_pulse_q, step_pulse_d;
  logic             aborted_q, aborted_d;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = (cmd_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
        end else if (timer_q == '0 && remaining_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
  end

  // Abort wins over a step that is due on the same edge, so position holds.
  always_comb begin
    pos_d        = pos_q;
    dir_d        = dir_q;
    remaining_d  = remaining_q;
    div_d        = div_q;
    timer_d      = timer_q;
    step_pulse_d = 1'b0;
    aborted_d    = aborted_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          pos_d = gray2bin(load_gray);
        end
        if (cmd_valid) begin
          dir_d       = cmd_dir;
          remaining_d = cmd_steps;
          div_d       = cmd_div;
          timer_d     = cmd_div;
          aborted_d   = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else if (timer_q == '0) begin
          pos_d        = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
          remaining_d  = remaining_q - 1'b1;
          timer_d      = div_q;
          step_pulse_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: ;
    endcase
    gray_d = pos_d ^ (pos_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q        <= '0;
      gray_q       <= '0;
      dir_q        <= 1'b0;
      remaining_q  <= '0;
      div_q        <= '0;
      timer_q      <= '0;
      step_pulse_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      gray_q       <= gray_d;
      dir_q        <= dir_d;
      remaining_q  <= remaining_d;
      div_q        <= div_d;
      timer_q      <= timer_d;
      step_pulse_q <= step_pulse_d;
      aborted_q    <= aborted_d;
    end
  end

  assign gray       = gray_q;
  assign step_pulse = step_pulse_q;
  assign aborted    = aborted_q;

endmodule
